// File: rtl/sata_gtx_pkg.sv
// Shared constants for the GTX receive path: K28.5 comma, framing primitives,
// lock/frame FSM encodings and the comma-lane finder.
package sata_gtx_pkg;

  localparam logic [7:0]  K28_5  = 8'hBC;
  localparam logic [31:0] W_IDLE = 32'h000000BC;
  localparam logic [31:0] W_SOF  = 32'h000050BC;
  localparam logic [31:0] W_EOF  = 32'h00005FBC;

  localparam logic [1:0] LK_HUNT   = 2'd0;
  localparam logic [1:0] LK_CHECK  = 2'd1;
  localparam logic [1:0] LK_LOCKED = 2'd2;

  localparam logic FR_IDLE     = 1'b0;
  localparam logic FR_IN_FRAME = 1'b1;

  typedef struct packed {
    logic       hit;
    logic [1:0] lane;
  } comma_t;

  // Lowest byte carrying a K28.5 wins, so scan from the top down.
  function automatic comma_t find_comma(input logic [31:0] data, input logic [3:0] isk);
    comma_t res;
    res = '0;
    for (int i = 3; i >= 0; i--) begin
      if (isk[i] && (data[8*i +: 8] == K28_5)) begin
        res.hit  = 1'b1;
        res.lane = 2'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/transceiver_read_if.sv
// AXI-Stream output bundle of the GTX receive channel.
interface transceiver_read_if;
  logic        m_axi_tvalid;
  logic        m_axi_tready;
  logic [31:0] m_axi_tdata;
  logic        m_axi_tlast;

  modport master (output m_axi_tvalid, output m_axi_tdata, output m_axi_tlast, input m_axi_tready);
  modport slave  (input m_axi_tvalid, input m_axi_tdata, input m_axi_tlast, output m_axi_tready);
endinterface

// File: rtl/transceiver_rx_fifo.sv
// First-word-fall-through FIFO buffering {tlast,data} beats toward the AXI-Stream port.
module transceiver_rx_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_en, rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/transceiver_read.sv
// GTX receive channel: comma aligner, link-lock FSM, SOF/EOF framer and AXI-Stream output buffer.
//   lock state | meaning
//   HUNT       | searching for a good K28.5 in any lane
//   CHECK      | counting consecutive good commas in the captured lane
//   LOCKED     | lane frozen, framing enabled, counting consecutive bad words
//   frame state| meaning
//   IDLE       | between frames, waiting for SOF
//   IN_FRAME   | collecting payload, one word held back to attach tlast
module transceiver_read #(
  parameter int LOCK_CNT   = 4,
  parameter int ERR_MAX    = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               gtx_ready,
  input  logic [31:0]        gt_rxdata_out,
  input  logic [3:0]         gt_rxcharisk_out,
  input  logic [3:0]         gt_rxdisperr_out,
  input  logic [3:0]         gt_rxnotintable_out,
  transceiver_read_if.master m_axi,
  output logic               rx_locked,
  output logic [15:0]        rx_err_cnt,
  output logic               rx_overflow
);
  import sata_gtx_pkg::*;

  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(ERR_MAX + 1);
  localparam logic [CW-1:0] LOCK_CNT_C = CW'(LOCK_CNT);
  localparam logic [BW-1:0] ERR_MAX_C  = BW'(ERR_MAX);

  logic [3:0] cur_err;
  logic       cur_bad;
  comma_t     cur_comma;

  assign cur_err   = gt_rxdisperr_out | gt_rxnotintable_out;
  assign cur_bad   = |cur_err;
  assign cur_comma = find_comma(gt_rxdata_out, gt_rxcharisk_out);

  logic [31:0] prev_data_q, prev_data_d;
  logic [3:0]  prev_k_q, prev_k_d;
  logic [3:0]  prev_err_q, prev_err_d;
  logic [31:0] al_data_q, al_data_d;
  logic [3:0]  al_k_q, al_k_d;
  logic [3:0]  al_err_q, al_err_d;
  logic [1:0]  lock_q, lock_d;
  logic [1:0]  lane_q, lane_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bad_cnt_q, bad_cnt_d;
  logic        frame_q, frame_d;
  logic [31:0] hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        overflow_q, overflow_d;

  logic [63:0] data_cat;
  logic [7:0]  k_cat, err_cat;
  logic        locked;
  logic        push, push_last, pop;
  logic [32:0] fifo_dout;
  logic        fifo_full, fifo_empty;

  // Aligned word straddles the previous and current GT words when lane != 0.
  assign data_cat = {gt_rxdata_out, prev_data_q};
  assign k_cat    = {gt_rxcharisk_out, prev_k_q};
  assign err_cat  = {cur_err, prev_err_q};

  always_comb begin
    prev_data_d = gt_rxdata_out;
    prev_k_d    = gt_rxcharisk_out;
    prev_err_d  = cur_err;
    al_data_d   = data_cat[{lane_q, 3'b000} +: 32];
    al_k_d      = k_cat[lane_q +: 4];
    al_err_d    = err_cat[lane_q +: 4];
  end

  always_comb begin
    lock_d    = lock_q;
    lane_d    = lane_q;
    cnt_d     = cnt_q;
    bad_cnt_d = bad_cnt_q;
    if (!gtx_ready) begin
      lock_d    = LK_HUNT;
      cnt_d     = '0;
      bad_cnt_d = '0;
    end else begin
      case (lock_q)
        LK_HUNT: begin
          if (cur_comma.hit && !cur_bad) begin
            lane_d = cur_comma.lane;
            cnt_d  = CW'(1);
            lock_d = LK_CHECK;
          end
        end
        LK_CHECK: begin
          if (cur_bad) begin
            lock_d = LK_HUNT;
            cnt_d  = '0;
          end else if (cur_comma.hit) begin
            if (cur_comma.lane == lane_q) begin
              cnt_d = cnt_q + 1'b1;
              if (cnt_q + 1'b1 == LOCK_CNT_C) begin
                lock_d    = LK_LOCKED;
                cnt_d     = '0;
                bad_cnt_d = '0;
              end
            end else begin
              lane_d = cur_comma.lane;
              cnt_d  = CW'(1);
            end
          end
        end
        LK_LOCKED: begin
          if (cur_bad || (cur_comma.hit && cur_comma.lane != lane_q)) begin
            if (bad_cnt_q + 1'b1 == ERR_MAX_C) begin
              lock_d    = LK_HUNT;
              bad_cnt_d = '0;
            end else begin
              bad_cnt_d = bad_cnt_q + 1'b1;
            end
          end else begin
            bad_cnt_d = '0;
          end
        end
        default: begin
          lock_d = LK_HUNT;
          cnt_d  = '0;
        end
      endcase
    end
  end

  assign locked = (lock_q == LK_LOCKED);

  // Corrupted aligned words are never treated as payload or primitives.
  always_comb begin
    frame_d    = frame_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    push       = 1'b0;
    push_last  = 1'b0;
    if (!locked) begin
      if (frame_q == FR_IN_FRAME) begin
        push       = hold_vld_q;
        push_last  = 1'b1;
        frame_d    = FR_IDLE;
        hold_vld_d = 1'b0;
      end
    end else if (al_err_q == 4'b0000) begin
      if (al_k_q == 4'b0001) begin
        if (al_data_q == W_SOF) begin
          if (frame_q == FR_IN_FRAME) begin
            push      = hold_vld_q;
            push_last = 1'b1;
          end
          frame_d    = FR_IN_FRAME;
          hold_vld_d = 1'b0;
        end else if (al_data_q == W_EOF && frame_q == FR_IN_FRAME) begin
          push       = hold_vld_q;
          push_last  = 1'b1;
          frame_d    = FR_IDLE;
          hold_vld_d = 1'b0;
        end
      end else if (al_k_q == 4'b0000 && frame_q == FR_IN_FRAME) begin
        push       = hold_vld_q;
        hold_d     = al_data_q;
        hold_vld_d = 1'b1;
      end
    end
  end

  assign pop = m_axi.m_axi_tvalid && m_axi.m_axi_tready;

  always_comb begin
    err_cnt_d  = err_cnt_q;
    if (cur_bad && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    overflow_d = overflow_q | (push && fifo_full && !pop);
  end

  transceiver_rx_fifo #(
    .WIDTH (33),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({push_last, hold_q}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_data_q <= '0;
      prev_k_q    <= '0;
      prev_err_q  <= '0;
      al_data_q   <= '0;
      al_k_q      <= '0;
      al_err_q    <= '0;
      lock_q      <= LK_HUNT;
      lane_q      <= '0;
      cnt_q       <= '0;
      bad_cnt_q   <= '0;
      frame_q     <= FR_IDLE;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      err_cnt_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      prev_data_q <= prev_data_d;
      prev_k_q    <= prev_k_d;
      prev_err_q  <= prev_err_d;
      al_data_q   <= al_data_d;
      al_k_q      <= al_k_d;
      al_err_q    <= al_err_d;
      lock_q      <= lock_d;
      lane_q      <= lane_d;
      cnt_q       <= cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      frame_q     <= frame_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      err_cnt_q   <= err_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  // Gate the buffer head so outputs read zero whenever nothing is presented.
  assign m_axi.m_axi_tvalid = !fifo_empty;
  assign m_axi.m_axi_tdata  = fifo_empty ? 32'd0 : fifo_dout[31:0];
  assign m_axi.m_axi_tlast  = fifo_empty ? 1'b0 : fifo_dout[32];
  assign rx_locked          = locked;
  assign rx_err_cnt         = err_cnt_q;
  assign rx_overflow        = overflow_q;

endmodule

// File: tb/tb_transceiver_read.sv
// Directed-vector bench for transceiver_read with a queue scoreboard and an independent beat monitor.
module tb_transceiver_read;

  localparam logic [31:0] IDLE = 32'h000000BC;
  localparam logic [31:0] SOF  = 32'h000050BC;
  localparam logic [31:0] EOF  = 32'h00005FBC;

  logic        clk = 1'b0;
  logic        rst;
  logic        gtx_ready;
  logic [31:0] rxdata;
  logic [3:0]  rxisk, rxdisp, rxnit;
  logic        rx_locked;
  logic [15:0] rx_err_cnt;
  logic        rx_overflow;

  transceiver_read_if m_axi ();

  transceiver_read dut (
    .clk                 (clk),
    .rst                 (rst),
    .gtx_ready           (gtx_ready),
    .gt_rxdata_out       (rxdata),
    .gt_rxcharisk_out    (rxisk),
    .gt_rxdisperr_out    (rxdisp),
    .gt_rxnotintable_out (rxnit),
    .m_axi               (m_axi),
    .rx_locked           (rx_locked),
    .rx_err_cnt          (rx_err_cnt),
    .rx_overflow         (rx_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          shift2   = 1'b0;
  logic [31:0] prev_w   = '0;
  logic [3:0]  prev_k   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && m_axi.m_axi_tvalid && m_axi.m_axi_tready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got %h last=%0d, expected no beat",
                 m_axi.m_axi_tdata, m_axi.m_axi_tlast);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_data", m_axi.m_axi_tdata, e.data);
        check("beat_last", 32'(m_axi.m_axi_tlast), 32'(e.last));
      end
    end
  end

  // Logical (lane-0) word in; in shift2 mode it is re-sliced as if the GT slipped by two bytes.
  task automatic gt(input logic [31:0] w, input logic [3:0] k, input logic [3:0] de);
    if (shift2) begin
      rxdata = {w[15:0], prev_w[31:16]};
      rxisk  = {k[1:0], prev_k[3:2]};
    end else begin
      rxdata = w;
      rxisk  = k;
    end
    rxdisp = de;
    rxnit  = 4'b0000;
    prev_w = w;
    prev_k = k;
    @(posedge clk);
    #1;
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) gt(IDLE, 4'b0001, 4'b0000);
  endtask

  task automatic dword(input logic [31:0] w);
    gt(w, 4'b0000, 4'b0000);
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_axi.m_axi_tvalid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic relock(input string name);
    idles(3);
    check({name, "_not_yet"}, 32'(rx_locked), 32'd0);
    idles(1);
    check({name, "_locked"}, 32'(rx_locked), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    gtx_ready = 1'b1;
    rxdata = '0;
    rxisk = '0;
    rxdisp = '0;
    rxnit = '0;
    m_axi.m_axi_tready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_tvalid", 32'(m_axi.m_axi_tvalid), 32'd0);
    check("rst_tdata", m_axi.m_axi_tdata, 32'd0);
    check("rst_tlast", 32'(m_axi.m_axi_tlast), 32'd0);
    check("rst_locked", 32'(rx_locked), 32'd0);
    check("rst_err_cnt", 32'(rx_err_cnt), 32'd0);
    check("rst_overflow", 32'(rx_overflow), 32'd0);
    rst = 1'b0;

    // Test 1: lane 0, three-word frame, latency of first beat
    relock("t1");
    expect_beat(32'h03020100, 1'b0);
    expect_beat(32'h07060504, 1'b0);
    expect_beat(32'h0B0A0908, 1'b1);
    gt(SOF, 4'b0001, 4'b0000);
    dword(32'h03020100);
    dword(32'h07060504);
    check("t1_lat_c1", 32'(m_axi.m_axi_tvalid), 32'd0);
    dword(32'h0B0A0908);
    check("t1_lat_c2", 32'(m_axi.m_axi_tvalid), 32'd0);
    gt(EOF, 4'b0001, 4'b0000);
    check("t1_lat_c3", 32'(m_axi.m_axi_tvalid), 32'd1);
    idles(4);
    drain("t1_drain");

    // Test 2: same stream slipped by two bytes, lock lands in lane 2
    gtx_ready = 1'b0;
    idles(1);
    gtx_ready = 1'b1;
    check("t2_hunt_after_gtx_ready", 32'(rx_locked), 32'd0);
    shift2 = 1'b1;
    relock("t2");
    expect_beat(32'h03020100, 1'b0);
    expect_beat(32'h07060504, 1'b0);
    expect_beat(32'h0B0A0908, 1'b1);
    gt(SOF, 4'b0001, 4'b0000);
    dword(32'h03020100);
    dword(32'h07060504);
    dword(32'h0B0A0908);
    gt(EOF, 4'b0001, 4'b0000);
    idles(4);
    drain("t2_drain");
    gtx_ready = 1'b0;
    idles(1);
    gtx_ready = 1'b1;
    shift2 = 1'b0;
    relock("t2_back_lane0");

    // Test 5: empty frame, then SOF restarting a frame
    gt(SOF, 4'b0001, 4'b0000);
    gt(EOF, 4'b0001, 4'b0000);
    idles(3);
    check("t5_empty_frame_no_beat", 32'(m_axi.m_axi_tvalid), 32'd0);
    expect_beat(32'hA5A50001, 1'b1);
    expect_beat(32'hA5A50002, 1'b1);
    gt(SOF, 4'b0001, 4'b0000);
    dword(32'hA5A50001);
    gt(SOF, 4'b0001, 4'b0000);
    dword(32'hA5A50002);
    gt(EOF, 4'b0001, 4'b0000);
    idles(4);
    drain("t5_drain");

    // Test 3: stalled sink, 20-word frame overflows a 16-entry buffer
    m_axi.m_axi_tready = 1'b0;
    gt(SOF, 4'b0001, 4'b0000);
    for (int i = 0; i < 20; i++) dword(32'h10000000 + 32'(i));
    gt(EOF, 4'b0001, 4'b0000);
    idles(4);
    check("t3_overflow", 32'(rx_overflow), 32'd1);
    check("t3_stall_tvalid", 32'(m_axi.m_axi_tvalid), 32'd1);
    check("t3_stall_tdata", m_axi.m_axi_tdata, 32'h10000000);
    idles(2);
    check("t3_stall_tdata_held", m_axi.m_axi_tdata, 32'h10000000);
    check("t3_stall_tlast_held", 32'(m_axi.m_axi_tlast), 32'd0);
    for (int i = 0; i < 16; i++) expect_beat(32'h10000000 + 32'(i), 1'b0);
    m_axi.m_axi_tready = 1'b1;
    drain("t3_drain");
    check("t3_overflow_sticky", 32'(rx_overflow), 32'd1);

    // Test 4: disparity errors mid-frame drop lock and truncate the frame
    expect_beat(32'hC0000000, 1'b0);
    expect_beat(32'hC0000001, 1'b0);
    expect_beat(32'hC0000002, 1'b1);
    gt(SOF, 4'b0001, 4'b0000);
    dword(32'hC0000000);
    dword(32'hC0000001);
    dword(32'hC0000002);
    gt(32'hDEAD0000, 4'b0000, 4'b0001);
    gt(32'hDEAD0001, 4'b0000, 4'b0001);
    gt(32'hDEAD0002, 4'b0000, 4'b0001);
    check("t4_still_locked_3bad", 32'(rx_locked), 32'd1);
    gt(32'hDEAD0003, 4'b0000, 4'b0001);
    check("t4_lock_lost", 32'(rx_locked), 32'd0);
    check("t4_err_cnt", 32'(rx_err_cnt), 32'd4);
    relock("t4_relock");
    drain("t4_drain");

    // Test 6: reset mid-frame with five words buffered
    m_axi.m_axi_tready = 1'b0;
    gt(SOF, 4'b0001, 4'b0000);
    for (int i = 0; i < 6; i++) dword(32'h60000000 + 32'(i));
    idles(2);
    check("t6_pre_rst_tvalid", 32'(m_axi.m_axi_tvalid), 32'd1);
    check("t6_pre_rst_tdata", m_axi.m_axi_tdata, 32'h60000000);
    rst = 1'b1;
    #1;
    check("t6_rst_tvalid", 32'(m_axi.m_axi_tvalid), 32'd0);
    check("t6_rst_tdata", m_axi.m_axi_tdata, 32'd0);
    check("t6_rst_tlast", 32'(m_axi.m_axi_tlast), 32'd0);
    check("t6_rst_locked", 32'(rx_locked), 32'd0);
    check("t6_rst_err_cnt", 32'(rx_err_cnt), 32'd0);
    check("t6_rst_overflow", 32'(rx_overflow), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_axi.m_axi_tready = 1'b1;
    relock("t6_relock");
    idles(3);
    drain("t6_no_stale_beats");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
